// File: rtl/mergesort_pkg.sv
// mergesort_pkg: shared sizes, initial data set, FSM states, default bases and address decode
package mergesort_pkg;
  localparam int N = 8;
  localparam int EW = 16;
  localparam int A_BASE_DEF = 64;
  localparam int B_BASE_DEF = 32;
  localparam logic [EW-1:0] INIT_DATA [N] = '{16'd7, 16'hFFFD, 16'd5, 16'd0, 16'd12, 16'hFFF8, 16'd1, 16'd4};
  typedef enum logic [1:0] {S_IDLE, S_MERGE, S_COPY, S_DONE} state_t;
  // Returns {hit, byte offset}: A occupies offsets 0..15, B occupies 16..31.
  function automatic logic [5:0] map_addr(input logic [7:0] a, input int ab, input int bb);
    int x;
    x = int'(a);
    return (x >= ab && x < ab + 16) ? {1'b1, 5'(x - ab)} :
           (x >= bb && x < bb + 16) ? {1'b1, 5'(x - bb + 16)} : 6'd0;
  endfunction
endpackage

// File: rtl/mergesort_mem.sv
// mergesort_mem: dual-lane byte RAM holding A and B, slave decode with 2/1-cycle latency, word port for the FSM
//   clock, reset (sync, active-low), idle: slave accesses honoured only when high
//   oe/we/addr/wdata -> rdata/rdy: two independent byte lanes
//   ra_addr/rb_addr -> ra_data/rb_data: combinational word reads; wr_en/wr_addr/wr_data: word write
module mergesort_mem
  import mergesort_pkg::*;
#(
  parameter int A_BASE = A_BASE_DEF,
  parameter int B_BASE = B_BASE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        idle,
  input  logic [1:0]  oe,
  input  logic [1:0]  we,
  input  logic [13:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic [1:0]  rdy,
  input  logic [7:0]  ra_addr,
  input  logic [7:0]  rb_addr,
  output logic [15:0] ra_data,
  output logic [15:0] rb_data,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [15:0] wr_data
);
  logic [7:0] mem [32];
  logic [1:0] s1_rd, s1_wr, s2_rd;
  logic [6:0] s1_addr [2];
  logic [7:0] s1_wd [2];
  logic [7:0] s2_data [2];
  logic [5:0] ma, mb, mw;
  logic [5:0] ms [2];
  always_comb begin
    ma = map_addr(ra_addr, A_BASE, B_BASE);
    mb = map_addr(rb_addr, A_BASE, B_BASE);
    mw = map_addr(wr_addr, A_BASE, B_BASE);
    ms[0] = map_addr({1'b0, s1_addr[0]}, A_BASE, B_BASE);
    ms[1] = map_addr({1'b0, s1_addr[1]}, A_BASE, B_BASE);
    ra_data = ma[5] ? {mem[ma[4:0] + 5'd1], mem[ma[4:0]]} : '0;
    rb_data = mb[5] ? {mem[mb[4:0] + 5'd1], mem[mb[4:0]]} : '0;
  end
  // Stage 1 registers the request; at the next edge writes commit and reads capture the
  // pre-write byte, so a same-cycle read/write pair returns the old value. Lane 1 is
  // written after lane 0 and therefore wins a same-byte collision.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int b = 0; b < 16; b++) mem[b[4:0]] <= b[0] ? INIT_DATA[b[3:1]][15:8] : INIT_DATA[b[3:1]][7:0];
      for (int b = 16; b < 32; b++) mem[b[4:0]] <= '0;
      s1_rd <= '0;
      s1_wr <= '0;
      s2_rd <= '0;
      rdy <= '0;
      rdata <= '0;
      for (int i = 0; i < 2; i++) begin
        s1_addr[i[0]] <= '0;
        s1_wd[i[0]] <= '0;
        s2_data[i[0]] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        s1_rd[i[0]] <= oe[i[0]] & idle;
        s1_wr[i[0]] <= we[i[0]] & idle;
        s1_addr[i[0]] <= addr[7*i +: 7];
        s1_wd[i[0]] <= wdata[8*i +: 8];
        s2_rd[i[0]] <= s1_rd[i[0]] & idle;
        s2_data[i[0]] <= ms[i[0]][5] ? mem[ms[i[0]][4:0]] : '0;
        rdy[i[0]] <= (s1_wr[i[0]] | s2_rd[i[0]]) & idle;
        rdata[8*i +: 8] <= s2_rd[i[0]] & idle ? s2_data[i[0]] : '0;
        if (s1_wr[i[0]] && idle && ms[i[0]][5]) mem[ms[i[0]][4:0]] <= s1_wd[i[0]];
      end
      if (wr_en && mw[5]) begin
        mem[mw[4:0]] <= wr_data[7:0];
        mem[mw[4:0] + 5'd1] <= wr_data[15:8];
      end
    end
  end
endmodule

// File: rtl/mergesort_main.sv
// mergesort_main: bottom-up merge sort of 8 signed 16-bit elements held in internal A/B storage
//   clock, reset (sync, active-low), start_port/done_port: one-cycle pulse handshake
//   S_*: two-lane byte slave port, active only while idle; Sout_*: read data and per-lane acknowledge
module mergesort_main
  import mergesort_pkg::*;
#(
  parameter int MEM_var_28859_28863 = A_BASE_DEF,
  parameter int MEM_var_28861_28867 = B_BASE_DEF,
  parameter int MEM_var_29023_28863 = B_BASE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [1:0]  S_oe_ram,
  input  logic [1:0]  S_we_ram,
  input  logic [13:0] S_addr_ram,
  input  logic [15:0] S_Wdata_ram,
  input  logic [7:0]  S_data_ram_size,
  output logic        done_port,
  output logic [15:0] Sout_Rdata_ram,
  output logic [1:0]  Sout_DataRdy
);
  state_t state;
  logic [2:0] cnt, base, w2m1, l_el, r_el;
  logic [3:0] width, li, ri;
  logic [15:0] ra, rb, wr_data;
  logic [7:0] a_base, v_base, ra_addr, rb_addr, wr_addr;
  logic take_left, wr_en, unused_size;
  assign unused_size = ^S_data_ram_size;
  // li/ri count elements already consumed from the left/right run of the current block.
  always_comb begin
    a_base = 8'(MEM_var_28859_28863);
    v_base = 8'(MEM_var_29023_28863);
    w2m1 = {width[1:0], 1'b0} - 3'd1;
    base = cnt & ~w2m1;
    l_el = base + li[2:0];
    r_el = base + width[2:0] + ri[2:0];
    ra_addr = state == S_COPY ? v_base + {4'd0, cnt, 1'b0} : a_base + {4'd0, l_el, 1'b0};
    rb_addr = a_base + {4'd0, r_el, 1'b0};
    take_left = li != width && (ri == width || $signed(ra) <= $signed(rb));
    wr_en = state == S_MERGE || state == S_COPY;
    wr_addr = (state == S_MERGE ? v_base : a_base) + {4'd0, cnt, 1'b0};
    wr_data = state == S_MERGE && !take_left ? rb : ra;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      width <= 4'd1;
      li <= '0;
      ri <= '0;
      done_port <= 1'b0;
    end else begin
      done_port <= 1'b0;
      case (state)
        S_IDLE: if (start_port) begin
          state <= S_MERGE;
          width <= 4'd1;
          cnt <= '0;
          li <= '0;
          ri <= '0;
        end
        S_MERGE: begin
          cnt <= cnt + 3'd1;
          if (li + ri == {1'b0, w2m1}) begin
            li <= '0;
            ri <= '0;
          end else if (take_left) li <= li + 4'd1;
          else ri <= ri + 4'd1;
          if (cnt == 3'd7) state <= S_COPY;
        end
        S_COPY: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            width <= width << 1;
            state <= width == 4'd4 ? S_DONE : S_MERGE;
          end
        end
        S_DONE: begin
          done_port <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end
  mergesort_mem #(.A_BASE(MEM_var_28859_28863), .B_BASE(MEM_var_28861_28867)) u_mem (
    .clock(clock),
    .reset(reset),
    .idle(state == S_IDLE),
    .oe(S_oe_ram),
    .we(S_we_ram),
    .addr(S_addr_ram),
    .wdata(S_Wdata_ram),
    .rdata(Sout_Rdata_ram),
    .rdy(Sout_DataRdy),
    .ra_addr(ra_addr),
    .rb_addr(rb_addr),
    .ra_data(ra),
    .rb_data(rb),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );
endmodule

// File: tb/tb_mergesort_main.sv
// tb_mergesort_main: table-driven sort vectors plus slave-port and reset corner sequences
module tb_mergesort_main;
  logic clock = 0, reset = 0, start_port = 0;
  logic [1:0] S_oe_ram = 0, S_we_ram = 0;
  logic [13:0] S_addr_ram = 0;
  logic [15:0] S_Wdata_ram = 0;
  logic [7:0] S_data_ram_size = 8'h88;
  logic done_port;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0] Sout_DataRdy;
  int checks = 0, errors = 0;
  typedef struct {
    logic wr;
    logic [15:0] din [8];
    logic [15:0] dout [8];
  } vec_t;
  vec_t vecs [5];
  logic [15:0] init_v [8] = '{16'd7, 16'hFFFD, 16'd5, 16'd0, 16'd12, 16'hFFF8, 16'd1, 16'd4};
  logic [15:0] zero_v [8] = '{default: 16'd0};
  logic [15:0] q;
  always #5 clock = ~clock;
  mergesort_main dut (
    .clock(clock),
    .reset(reset),
    .start_port(start_port),
    .S_oe_ram(S_oe_ram),
    .S_we_ram(S_we_ram),
    .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram),
    .S_data_ram_size(S_data_ram_size),
    .done_port(done_port),
    .Sout_Rdata_ram(Sout_Rdata_ram),
    .Sout_DataRdy(Sout_DataRdy)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // One slave transaction: write ack expected one cycle after the request, read data two cycles after.
  task automatic xact(input logic [1:0] o, input logic [1:0] w, input logic [13:0] a, input logic [15:0] d, output logic [15:0] r);
    logic [1:0] r1;
    @(negedge clock);
    S_oe_ram = o; S_we_ram = w; S_addr_ram = a; S_Wdata_ram = d;
    @(negedge clock);
    S_oe_ram = 0; S_we_ram = 0;
    @(negedge clock);
    r1 = Sout_DataRdy;
    @(negedge clock);
    r = Sout_Rdata_ram;
    chk("ack_timing", {r1, Sout_DataRdy}, {w, o});
  endtask
  task automatic wr_elem(input logic [6:0] a, input logic [15:0] v);
    logic [15:0] dummy;
    xact(2'b00, 2'b11, {a + 7'd1, a}, v, dummy);
  endtask
  task automatic check_array(input string n, input logic [6:0] base, input logic [15:0] exp [8]);
    logic [15:0] v;
    for (int j = 0; j < 8; j++) begin
      xact(2'b11, 2'b00, {base + 7'(2*j+1), base + 7'(2*j)}, 16'd0, v);
      chk(n, v, exp[j]);
    end
  endtask
  // Start a sort and measure start-to-done latency; optionally poke the slave port and start mid-sort.
  task automatic run_sort(input bit disturb);
    int n;
    bit seen;
    @(negedge clock); start_port = 1;
    @(negedge clock); start_port = 0;
    n = 0;
    seen = 0;
    do begin
      if (disturb) begin
        S_oe_ram = n == 9 ? 2'b11 : 2'b00;
        S_we_ram = n == 29 ? 2'b01 : 2'b00;
        S_addr_ram = {7'd65, 7'd64};
        S_Wdata_ram = 16'h00AA;
        start_port = n == 19;
      end
      @(negedge clock);
      n++;
      seen |= Sout_DataRdy != 2'b00;
    end while (!done_port && n < 200);
    S_oe_ram = 0; S_we_ram = 0; start_port = 0;
    chk("latency", n, 49);
    if (disturb) chk("busy_rdy", seen, 0);
    @(negedge clock);
    chk("done_pulse", done_port, 0);
  endtask
  initial begin
    vecs[0] = '{1'b0, '{16'd7, 16'hFFFD, 16'd5, 16'd0, 16'd12, 16'hFFF8, 16'd1, 16'd4},
                      '{16'hFFF8, 16'hFFFD, 16'd0, 16'd1, 16'd4, 16'd5, 16'd7, 16'd12}};
    vecs[1] = '{1'b1, '{16'd3, 16'd3, 16'hFFFF, 16'd2, 16'h7FFF, 16'h8000, 16'd5, 16'd5},
                      '{16'h8000, 16'hFFFF, 16'd2, 16'd3, 16'd3, 16'd5, 16'd5, 16'h7FFF}};
    vecs[2] = '{1'b1, '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
                      '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8}};
    vecs[3] = '{1'b1, '{default: 16'hFFFF}, '{default: 16'hFFFF}};
    vecs[4] = '{1'b1, '{16'h8000, 16'h7FFF, 16'd0, 16'hFFFF, 16'd1, 16'h8000, 16'h7FFF, 16'd0},
                      '{16'h8000, 16'h8000, 16'hFFFF, 16'd0, 16'd0, 16'd1, 16'h7FFF, 16'h7FFF}};
    repeat (3) @(negedge clock);
    chk("rst_done", done_port, 0);
    chk("rst_rdy", Sout_DataRdy, 0);
    chk("rst_rdata", Sout_Rdata_ram, 0);
    reset = 1;
    check_array("init_A", 7'd64, init_v);
    check_array("init_B", 7'd32, zero_v);
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].wr) for (int j = 0; j < 8; j++) wr_elem(7'(64 + 2*j), vecs[v].din[j]);
      run_sort(0);
      check_array($sformatf("sort%0d_A", v), 7'd64, vecs[v].dout);
      check_array($sformatf("sort%0d_B", v), 7'd32, vecs[v].dout);
      if (v == 0) begin
        xact(2'b01, 2'b00, {7'd0, 7'd64}, 16'd0, q);
        chk("first_byte", q[7:0], 8'hF8);
      end
    end
    run_sort(1);
    check_array("resort_A", 7'd64, vecs[4].dout);
    xact(2'b00, 2'b01, {7'd0, 7'h7F}, 16'h005A, q);
    xact(2'b11, 2'b00, {7'd0, 7'h7F}, 16'd0, q);
    chk("unmapped_rd", q, 0);
    xact(2'b00, 2'b11, {7'd64, 7'd64}, 16'h2211, q);
    xact(2'b01, 2'b00, {7'd0, 7'd64}, 16'd0, q);
    chk("lane1_wins", q[7:0], 8'h22);
    xact(2'b01, 2'b10, {7'd64, 7'd64}, 16'h3300, q);
    chk("rd_old", q[7:0], 8'h22);
    xact(2'b10, 2'b00, {7'd64, 7'd0}, 16'd0, q);
    chk("rd_new", q[15:8], 8'h33);
    begin
      bit seen_done;
      seen_done = 0;
      @(negedge clock); start_port = 1;
      @(negedge clock); start_port = 0;
      repeat (19) @(negedge clock);
      reset = 0;
      @(negedge clock);
      seen_done |= done_port;
      reset = 1;
      repeat (80) begin
        @(negedge clock);
        seen_done |= done_port;
      end
      chk("abort_no_done", seen_done, 0);
    end
    check_array("abort_A", 7'd64, init_v);
    check_array("abort_B", 7'd32, zero_v);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
